// File: rtl/fifo_drain_arbiter_pkg.sv
// fifo_drain_arbiter_pkg: state encoding and default sizing shared by the drain arbiter
package fifo_drain_arbiter_pkg;
   typedef enum logic {IDLE, SEND} state_t;
   localparam int DATAWIDTH = 8;
   localparam int BURSTLEN  = 16;
endpackage

// File: rtl/fifo_drain_arbiter.sv
// fifo_drain_arbiter: round-robin bursts from two FWFT FIFOs into one registered byte sink
module fifo_drain_arbiter
   import fifo_drain_arbiter_pkg::*;
#(
   parameter int c_DATAWIDTH = DATAWIDTH,
   parameter int c_BURSTLEN  = BURSTLEN
) (
   input  logic                   i_clock,
   input  logic                   i_resetn,
   input  logic                   i_empty0,
   input  logic [c_DATAWIDTH-1:0] i_data0,
   output logic                   o_readen0,
   input  logic                   i_empty1,
   input  logic [c_DATAWIDTH-1:0] i_data1,
   output logic                   o_readen1,
   output logic [c_DATAWIDTH-1:0] o_data,
   output logic                   o_valid,
   input  logic                   i_ready,
   output logic                   o_grant,
   output logic                   o_busy
);
   localparam int CW = $clog2(c_BURSTLEN + 1);
   localparam logic [CW-1:0] MAX = CW'(c_BURSTLEN);
   state_t                 state_q;
   logic [c_DATAWIDTH-1:0] data_q, data_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   grant_q, last_q, idle, pick, start, cont, pop, src;
   assign idle  = state_q == IDLE;
   assign pick  = (!i_empty0 && !i_empty1) ? ~last_q : i_empty0;
   assign start = idle && !(i_empty0 && i_empty1);
   // a transfer keeps the burst alive only while the granted FIFO still has data and the count allows
   assign cont  = !idle && i_ready && cnt_q < MAX && !(grant_q ? i_empty1 : i_empty0);
   assign pop   = i_resetn && (start || cont);
   assign src   = idle ? pick : grant_q;
   assign o_readen0 = pop && !src;
   assign o_readen1 = pop && src;
   assign data_d = src ? i_data1 : i_data0;
   assign cnt_d  = idle ? CW'(1) : cnt_q + CW'(1);
   always_ff @(posedge i_clock) begin
      if (!i_resetn) begin
         state_q <= IDLE;
         data_q  <= '0;
         cnt_q   <= '0;
         grant_q <= 1'b0;
         last_q  <= 1'b1;
      end else if (start) begin
         state_q <= SEND;
         grant_q <= pick;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
      end else if (cont) begin
         data_q  <= data_d;
         cnt_q   <= cnt_d;
      end else if (!idle && i_ready) begin
         last_q  <= grant_q;
         state_q <= IDLE;
      end
   end
   assign o_data  = data_q;
   assign o_valid = state_q == SEND;
   assign o_busy  = !idle;
   assign o_grant = grant_q;
endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// tb_fifo_drain_arbiter: queue-backed FIFOs, transaction-level model and directed/random checks
module tb_fifo_drain_arbiter;
   localparam int BL = 16;
   logic       clk = 1'b0;
   logic       i_resetn = 1'b0, i_ready = 1'b0;
   logic       i_empty0 = 1'b1, i_empty1 = 1'b1;
   logic [7:0] i_data0 = '0, i_data1 = '0;
   logic       re0, re1, o_valid, o_grant, o_busy;
   logic [7:0] o_data;
   logic [7:0] f0[$], f1[$];
   logic [7:0] out_q[$];
   bit         out_g[$];
   int         out_c[$];
   int         n_chk = 0, n_err = 0, cyc = 0;
   bit         p0 = 0, p1 = 0;
   bit         m_busy = 0, m_grant = 0, m_last = 1;
   int         m_cnt = 0;
   logic [7:0] m_data = '0;

   fifo_drain_arbiter dut (
      .i_clock(clk), .i_resetn(i_resetn),
      .i_empty0(i_empty0), .i_data0(i_data0), .o_readen0(re0),
      .i_empty1(i_empty1), .i_data1(i_data1), .o_readen1(re1),
      .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
      .o_grant(o_grant), .o_busy(o_busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // one clock: apply last cycle's pops, drive inputs, compare, then advance the model
   task automatic step(input bit rdy, input bit rn);
      bit x0, x1, s;
      x0 = 0;
      x1 = 0;
      @(negedge clk);
      if (p0 && f0.size() > 0) void'(f0.pop_front());
      if (p1 && f1.size() > 0) void'(f1.pop_front());
      i_ready  = rdy;
      i_resetn = rn;
      i_empty0 = f0.size() == 0;
      i_empty1 = f1.size() == 0;
      i_data0  = i_empty0 ? 8'($urandom) : f0[0];
      i_data1  = i_empty1 ? 8'($urandom) : f1[0];
      #1;
      check("o_valid", o_valid, m_busy);
      check("o_busy", o_busy, m_busy);
      check("o_grant", o_grant, m_grant);
      check("o_data", o_data, m_data);
      check("readen_both", re0 && re1, 0);
      check("readen0_empty", re0 && i_empty0, 0);
      check("readen1_empty", re1 && i_empty1, 0);
      if (rn && o_valid && rdy) begin
         out_q.push_back(o_data);
         out_g.push_back(o_grant);
         out_c.push_back(cyc);
      end
      if (!rn) begin
         m_busy = 0; m_data = '0; m_grant = 0; m_cnt = 0; m_last = 1;
      end else if (!m_busy) begin
         if (f0.size() > 0 || f1.size() > 0) begin
            s = (f0.size() > 0 && f1.size() > 0) ? !m_last : (f0.size() == 0);
            m_data = s ? f1[0] : f0[0];
            x0 = !s; x1 = s;
            m_grant = s; m_cnt = 1; m_busy = 1;
         end
      end else if (rdy) begin
         if (m_cnt < BL && (m_grant ? f1.size() : f0.size()) > 0) begin
            m_data = m_grant ? f1[0] : f0[0];
            x0 = !m_grant; x1 = m_grant;
            m_cnt++;
         end else begin
            m_last = m_grant; m_busy = 0;
         end
      end
      check("o_readen0", re0, x0);
      check("o_readen1", re1, x1);
      p0 = x0; p1 = x1;
      cyc++;
   endtask

   task automatic restart();
      step(1, 0);
      f0.delete(); f1.delete();
      out_q.delete(); out_g.delete(); out_c.delete();
   endtask

   initial begin
      int exp_b, gap;
      bit exp_s;
      repeat (3) @(posedge clk);
      // three bytes from source 0 only
      restart();
      f0 = '{8'h11, 8'h22, 8'h33};
      repeat (8) step(1, 1);
      check("s1_count", out_q.size(), 3);
      for (int i = 0; i < 3 && i < out_q.size(); i++) begin
         check("s1_byte", out_q[i], 8'h11 * (i + 1));
         check("s1_grant", out_g[i], 0);
         if (i > 0) check("s1_gap", out_c[i] - out_c[i-1], 1);
      end
      check("s1_idle", o_busy, 0);
      // two full sources, 16-byte bursts alternate
      restart();
      for (int i = 0; i < 20; i++) begin
         f0.push_back(8'(8'hA0 + i));
         f1.push_back(8'(8'hB0 + i));
      end
      repeat (50) step(1, 1);
      check("s2_count", out_q.size(), 40);
      for (int i = 0; i < 40 && i < out_q.size(); i++) begin
         exp_s = (i >= 16 && i < 32) || i >= 36;
         exp_b = i < 16 ? 8'hA0 + i : i < 32 ? 8'hB0 + i - 16 : i < 36 ? 8'hB0 + i - 32 : 8'hC0 + i - 36;
         check("s2_byte", out_q[i], exp_b);
         check("s2_grant", out_g[i], exp_s);
         if (i > 0) begin
            gap = (i == 16 || i == 32 || i == 36) ? 2 : 1;
            check("s2_gap", out_c[i] - out_c[i-1], gap);
         end
      end
      // sink stall holds the byte
      restart();
      f0 = '{8'h11, 8'h22, 8'h33};
      for (int i = 0; i < 10 && !o_valid; i++) step(0, 1);
      check("s3_valid", o_valid, 1);
      repeat (5) begin
         step(0, 1);
         check("s3_hold", o_data, 8'h11);
         check("s3_noread", re0 || re1, 0);
      end
      step(1, 1);
      step(1, 1);
      check("s3_next", o_data, 8'h22);
      check("s3_next_valid", o_valid, 1);
      // source 0 runs dry early, source 1 takes over
      restart();
      f0 = '{8'h50, 8'h51, 8'h52};
      f1 = '{8'h60, 8'h61, 8'h62, 8'h63, 8'h64};
      repeat (20) step(1, 1);
      check("s4_count", out_q.size(), 8);
      for (int i = 0; i < 8 && i < out_q.size(); i++) begin
         check("s4_byte", out_q[i], i < 3 ? 8'h50 + i : 8'h60 + i - 3);
         check("s4_grant", out_g[i], i >= 3);
      end
      if (out_c.size() > 3) check("s4_gap", out_c[3] - out_c[2], 2);
      // reset mid-burst discards the held byte
      restart();
      for (int i = 0; i < 10; i++) begin
         f0.push_back(8'(8'hC0 + i));
         f1.push_back(8'(8'hD0 + i));
      end
      repeat (4) step(1, 1);
      step(1, 0);
      step(1, 1);
      check("s5_valid", o_valid, 0);
      check("s5_busy", o_busy, 0);
      step(1, 1);
      check("s5_grant", o_grant, 0);
      check("s5_data", o_data, 8'hC4);
      // random traffic against the model
      restart();
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 3) == 0 && f0.size() < 40) f0.push_back(8'($urandom));
         if ($urandom_range(0, 3) == 0 && f1.size() < 40) f1.push_back(8'($urandom));
         step($urandom_range(0, 9) < 7, $urandom_range(0, 199) != 0);
      end
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/fifo_drain_arbiter.md
FIFO_DRAIN_ARBITER -- requirements
Module: fifo_drain_arbiter

Interface
REQ-001 SHALL have parameter c_DATAWIDTH, default 8, byte width of all data ports.
REQ-002 SHALL have parameter c_BURSTLEN, default 16, maximum bytes taken from one source per grant (range 1..256).
REQ-003 SHALL have port i_clock  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port i_resetn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port i_empty0  input  1  source-0 FIFO empty flag.
REQ-006 SHALL have port i_data0  input  c_DATAWIDTH  source-0 FIFO head byte, valid while i_empty0 low.
REQ-007 SHALL have port o_readen0  output  1  source-0 FIFO pop strobe.
REQ-008 SHALL have ports i_empty1, i_data1 and o_readen1, identical to the source-0 ports, for source 1.
REQ-009 SHALL have port o_data  output  c_DATAWIDTH  registered byte to sink.
REQ-010 SHALL have port o_valid  output  1  o_data holds an untransferred byte.
REQ-011 SHALL have port i_ready  input  1  sink accepts o_data this cycle when o_valid high.
REQ-012 SHALL have port o_grant  output  1  source index of the current or last burst.
REQ-013 SHALL have port o_busy  output  1  high whenever state is not IDLE.

Function
REQ-014 SHALL treat each source as a first-word-fall-through FIFO: a one-cycle readen pops the head; the empty flag and head data are valid on the following cycle.
REQ-015 SHALL implement states IDLE and SEND.
REQ-016 SHALL, in IDLE with at least one source non-empty, select a source, capture its head into o_data, pulse its readen that cycle, load burst count 1, and enter SEND.
REQ-017 SHALL select round-robin in IDLE: when both sources are non-empty, grant the source opposite r_LAST; when only one is non-empty, grant that source.
REQ-018 SHALL drive o_valid high for the whole of SEND; a transfer occurs on a cycle where o_valid and i_ready are both high.
REQ-019 SHALL hold o_data, o_valid and o_grant stable in SEND while i_ready is low.
REQ-020 SHALL, on a transfer where the burst count is below c_BURSTLEN and the granted source is non-empty, capture the next head, pulse that readen, increment the count and stay in SEND (1 byte/cycle).
REQ-021 SHALL, on any other transfer, set r_LAST to the granted source and go to IDLE; this costs one bubble cycle.
REQ-022 SHALL drive o_readen0 and o_readen1 combinationally, never both high in one cycle, and never to a source whose empty flag is high.
REQ-023 SHALL never pop the non-granted source during SEND.
REQ-024 SHALL hold the burst count in a counter wide enough for c_BURSTLEN; the counter SHALL NOT wrap.

Reset
REQ-025 SHALL, while i_resetn is low at a clock edge, enter IDLE with o_valid=0, o_data=0, o_grant=0, o_busy=0, burst count 0 and r_LAST=1 (source 0 preferred first).
REQ-026 SHALL hold o_readen0 and o_readen1 low while i_resetn is low.
REQ-027 SHALL discard a byte held in o_data when reset occurs mid-burst; the byte is not re-fetched.

Structure
REQ-028 SHALL place the state encoding (IDLE, SEND) and the default c_DATAWIDTH and c_BURSTLEN constants in the shared project package.
REQ-029 SHALL be a single module with no sub-modules, connecting directly to two FIFO instances and one byte sink.

Verification
REQ-030 Bench SHALL cover: source 0 holds 0x11,0x22,0x33, source 1 empty, i_ready=1 -> o_data 0x11,0x22,0x33 on consecutive cycles, o_grant=0, then IDLE.
REQ-031 Bench SHALL cover: both sources hold 20 bytes (0xA0.. and 0xB0..), c_BURSTLEN=16, i_ready=1 -> 16 bytes from source 0, one bubble, 16 bytes from source 1, one bubble, then 4 bytes from source 0, one bubble, then 4 bytes from source 1.
REQ-032 Bench SHALL cover: i_ready low for 5 cycles while o_valid=1 -> o_data stable, no readen pulses, 0x22 follows on the first cycle with i_ready high.
REQ-033 Bench SHALL cover: source 0 drains empty after 3 of 16 bytes while source 1 is non-empty -> burst ends early and the next grant is source 1.
REQ-034 Bench SHALL cover: i_resetn low for one cycle mid-burst -> next cycle o_valid=0 and o_busy=0; the restart grants source 0.
REQ-035 Bench SHALL check, every cycle, that readen is never asserted to an empty source and that both readens are never high together.
